// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: FSM encoding, status layout and CPU addresses.
package uart_tx_port_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int unsigned DATA_W       = 8;
   localparam int unsigned BIT_IDX_W    = 3;

   localparam int unsigned STAT_READY   = 0;
   localparam int unsigned STAT_BUSY    = 1;
   localparam int unsigned STAT_OVF     = 2;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 3;

   localparam logic [15:0] UART_CHK = 16'h00fa;
   localparam logic [15:0] UART_DAT = 16'h00f9;

   // Assemble the CPU-visible status word; unused bits read as zero.
   function automatic logic [15:0] pack_status(input logic                  ready,
                                               input logic                  busy,
                                               input logic                  ovf,
                                               input logic [STAT_CNT_W-1:0] cnt);
      logic [15:0] s;
      s                             = '0;
      s[STAT_READY]                 = ready;
      s[STAT_BUSY]                  = busy;
      s[STAT_OVF]                   = ovf;
      s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter; pushes into a full FIFO are ignored even alongside a pop.
module uart_fifo
   import uart_tx_port_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_q];
   assign count   = count_q;

   // Storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= din;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_port.sv
// Buffered 8N1 UART transmitter with CPU status word and sticky overflow flag.
module uart_tx_port
   import uart_tx_port_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned DEPTH        = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DATA_W-1:0] datain,
   input  logic              clr_ovf,
   output logic [15:0]       status,
   output logic              tx
);

   localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
   localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_e             state_q;
   tx_state_e             state_d;
   logic [BAUD_W-1:0]     baud_q;
   logic [BAUD_W-1:0]     baud_d;
   logic [BIT_IDX_W-1:0]  bit_q;
   logic [BIT_IDX_W-1:0]  bit_d;
   logic [DATA_W-1:0]     shift_q;
   logic [DATA_W-1:0]     shift_d;
   logic                  tx_q;
   logic                  tx_d;
   logic                  ovf_q;
   logic                  ovf_d;
   logic                  pop;
   logic                  baud_last;
   logic [DATA_W-1:0]     fifo_dout;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

   uart_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr),
      .pop   (pop),
      .din   (datain),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign baud_last = (baud_q == BAUD_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!fifo_empty)                         state_d = ST_START;
         ST_START: if (baud_last)                           state_d = ST_DATA;
         ST_DATA:  if (baud_last && (bit_q == 3'd7))        state_d = ST_STOP;
         ST_STOP:  if (baud_last)                           state_d = ST_IDLE;
         default:                                           state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values; tx is computed from the upcoming state so it registers in step.
   always_comb begin
      pop     = 1'b0;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
            if (baud_last) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + BIT_IDX_W'(1);
            end
         end
         default: begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
         end
      endcase

      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase

      // An overflowing write wins over a simultaneous clear.
      if (wr && fifo_full) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

   assign tx     = tx_q;
   assign status = pack_status(!fifo_full,
                               (state_q != ST_IDLE) || !fifo_empty,
                               ovf_q,
                               STAT_CNT_W'(fifo_count));

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_port;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FRAME = 10 * CPB;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        wr      = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [7:0]  datain  = 8'h00;
   logic [15:0] status;
   logic        tx;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Reference model state: byte queue, current frame and its cycle position.
   logic [7:0] m_q[$];
   logic [7:0] m_log[$];
   logic [7:0] m_cur    = 8'h00;
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   bit         m_ovf    = 1'b0;

   uart_tx_port #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr),
      .datain  (datain),
      .clr_ovf (clr_ovf),
      .status  (status),
      .tx      (tx)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Frame bit k of an 8N1 frame: start, 8 data bits LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   function logic exp_tx();
      return m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
   endfunction

   function logic [15:0] exp_status();
      logic [15:0] s;
      int n;
      n      = m_q.size();
      s      = '0;
      s[0]   = (n < DEPTH);
      s[1]   = m_active || (n != 0);
      s[2]   = m_ovf;
      s[6:4] = 3'(n);
      return s;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model advances on each edge, or clears immediately on reset.
   initial begin
      forever begin
         int sz;
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
         end else begin
            sz = m_q.size();
            if (m_active) begin
               m_pos++;
               if (m_pos == FRAME) m_active = 1'b0;
            end else if (sz != 0) begin
               m_cur    = m_q.pop_front();
               m_log.push_back(m_cur);
               m_active = 1'b1;
               m_pos    = 0;
            end
            if (wr && sz < DEPTH) m_q.push_back(datain);
            if (wr && sz == DEPTH) m_ovf = 1'b1;
            else if (clr_ovf)      m_ovf = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cyc_tx", 16'(tx), 16'(exp_tx()));
            check("cyc_status", status, exp_status());
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wr     = 1'b1;
      datain = b;
      @(negedge clk);
      wr     = 1'b0;
   endtask

   initial begin
      logic [9:0] seq;
      logic [7:0] exp2 [5];
      int         lsz;
      seq  = 10'b1101001010;
      exp2 = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};

      #2 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      @(negedge clk);
      check("rst_status", status, 16'h0001);
      check("rst_tx", 16'(tx), 16'h0001);
      wait_neg(2);
      #2 rst_n = 1'b1;

      // Single byte 0xA5: idle on the write edge, start bit from the next edge.
      write_byte(8'hA5);
      check("s1_pre_pop_tx", 16'(tx), 16'h0001);
      for (int i = 0; i < int'(FRAME); i++) begin
         @(negedge clk);
         check("s1_bit", 16'(tx), 16'(seq[i/int'(CPB)]));
      end
      @(negedge clk);
      check("s1_end_tx", 16'(tx), 16'h0001);
      check("s1_end_status", status, 16'h0001);

      // Overflow while busy, clear, then clear racing an overflowing write.
      lsz = m_log.size();
      write_byte(8'hAA);
      wait_neg(2);
      for (int v = 1; v <= 5; v++) begin
         @(negedge clk);
         wr     = 1'b1;
         datain = 8'(v);
      end
      @(negedge clk);
      wr = 1'b0;
      check("s2_full_ovf", status, 16'h0046);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("s2_clr", status, 16'h0042);
      wr      = 1'b1;
      datain  = 8'h06;
      clr_ovf = 1'b1;
      @(negedge clk);
      wr      = 1'b0;
      clr_ovf = 1'b0;
      check("s2_clr_vs_ovf", status, 16'h0046);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("s2_clr2", status, 16'h0042);
      wait_neg(220);
      check("s2_drained", status, 16'h0001);
      check("s2_log_len", 16'(m_log.size() - lsz), 16'd5);
      for (int i = 0; i < 5; i++) begin
         if (m_log.size() > lsz + i)
            check("s2_log_byte", 16'(m_log[lsz+i]), 16'(exp2[i]));
      end

      // Back-to-back bytes: one idle cycle between frames, busy held throughout.
      @(negedge clk);
      wr     = 1'b1;
      datain = 8'h3C;
      @(negedge clk);
      datain = 8'hC3;
      @(negedge clk);
      wr     = 1'b0;
      wait_neg(39);
      check("s3_stop1_tx", 16'(tx), 16'h0001);
      check("s3_stop1_status", status, 16'h0013);
      @(negedge clk);
      check("s3_gap_tx", 16'(tx), 16'h0001);
      check("s3_gap_status", status, 16'h0013);
      @(negedge clk);
      check("s3_start2_tx", 16'(tx), 16'h0000);
      check("s3_start2_status", status, 16'h0003);
      wait_neg(39);
      check("s3_stop2_tx", 16'(tx), 16'h0001);
      check("s3_stop2_status", status, 16'h0003);
      @(negedge clk);
      check("s3_done_status", status, 16'h0001);

      // Reset during data bit 3 of 0x35 (that bit is 0).
      write_byte(8'h35);
      wait_neg(18);
      check("s4_bit3_tx", 16'(tx), 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      check("s4_rst_tx", 16'(tx), 16'h0001);
      check("s4_rst_status", status, 16'h0001);
      wait_neg(2);
      #2 rst_n = 1'b1;
      wait_neg(60);
      check("s4_after_tx", 16'(tx), 16'h0001);
      check("s4_after_status", status, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208; clock cycles per bit (9600 baud at 50 MHz).
REQ-002 SHALL have parameter DEPTH, default 4; FIFO entries, power of two.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  input  1  CPU write strobe (memld AND data-address match), one cycle per byte.
REQ-006 SHALL have port datain  input  8  byte presented with wr.
REQ-007 SHALL have port clr_ovf  input  1  one-cycle strobe (memld AND status-address match) that clears the overflow flag.
REQ-008 SHALL have port status  output  16  combinational status word for CPU read.
REQ-009 SHALL have port tx  output  1  serial line; idles high.

Function
REQ-010 SHALL buffer bytes in a DEPTH-entry FIFO with a write pointer, a read pointer and a count of width log2(DEPTH)+1.
REQ-011 SHALL treat wr with count<DEPTH as a push on that clock edge.
REQ-012 SHALL drop the byte when wr arrives with count==DEPTH, even if a pop occurs in the same cycle, and SHALL set the sticky ovf flag.
REQ-013 SHALL clear ovf on clr_ovf; if clr_ovf and an overflowing wr occur in the same cycle, ovf SHALL end up 1.
REQ-014 SHALL define status as: bit0 ready (count<DEPTH); bit1 busy (FSM not IDLE or count!=0); bit2 ovf; bits[6:4] count; all other bits 0.
REQ-015 SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-016 SHALL, in IDLE with count!=0, pop the head byte into the shift register, reset the baud counter and the bit index, and enter START on that edge.
REQ-017 SHALL drive tx as follows: 1 in IDLE and STOP; 0 in START; shift-register bit 0 in DATA (LSB first).
REQ-018 SHALL hold each of START, each DATA bit, and STOP for exactly CLKS_PER_BIT cycles, counted by a baud counter from 0 to CLKS_PER_BIT-1 that wraps to 0.
REQ-019 SHALL move START to DATA on the terminal baud count.
REQ-020 SHALL, in DATA, shift right and increment the 3-bit bit index on each terminal count, and enter STOP after index 7.
REQ-021 SHALL move STOP to IDLE on its terminal count.
REQ-022 SHALL allow a back-to-back byte to start on the cycle after the STOP-to-IDLE edge, giving a 1-cycle inter-frame idle.
REQ-023 SHALL, for a push into an empty FIFO while IDLE at edge N, pop at edge N+1 and drive tx low from edge N+1.
REQ-024 SHALL allow a simultaneous push and pop on a non-full FIFO, leaving count unchanged.
REQ-025 SHALL wrap the FIFO pointers modulo DEPTH.
REQ-026 SHALL register tx, with no combinational path from inputs to tx.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear FSM to IDLE, tx to 1, FIFO pointers and count to 0, ovf to 0, baud counter, bit index and shift register to 0.
REQ-028 SHALL abort a frame in progress when reset is asserted mid-frame: tx returns high immediately and buffered bytes are discarded.
REQ-029 SHALL output status = 16'h0001 while in reset.

Structure
REQ-030 SHALL place in the shared package: the FSM state encoding, the status bit positions, and the address constants UART_CHK = 16'h00fa (status read / clr_ovf) and UART_DAT = 16'h00f9 (data write).
REQ-031 SHALL implement the FIFO as one sub-module, uart_fifo (push, pop, din, dout, count, full, empty); the FSM and baud logic SHALL stay in uart_tx_port.
REQ-032 SHALL keep address decode in the top level; this block receives only wr and clr_ovf strobes.

Verification
REQ-033 SHALL cover: CLKS_PER_BIT=4, reset, write 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total; tx low from the 2nd edge after wr.
REQ-034 SHALL cover: 5 consecutive wr of 8'h01..8'h05 while the FSM is busy with an earlier byte -> status count=4, ready=0, 8'h05 dropped, ovf=1; serial output is 01,02,03,04 only.
REQ-035 SHALL cover: clr_ovf after REQ-034 -> status bit2=0; then wr while full with clr_ovf in the same cycle -> ovf=1.
REQ-036 SHALL cover: rst_n pulsed low during DATA bit 3 -> tx=1 in the same cycle, status=16'h0001, no further start bit.
REQ-037 SHALL cover: two bytes written back-to-back -> exactly one idle-high cycle between the stop bit and the second start bit; busy=1 throughout, busy=0 one cycle after the final STOP.
